// File: rtl/pipe_ctrl.sv
// Pipeline control for the IF/ID/EX core: converts jump, EX hold, bus wait and
// load-use hazards into per-stage hold/flush controls, plus two perf counters.
module pipe_ctrl #(
  parameter int unsigned JUMP_FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_hold_i,
  input  logic        bus_hold_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_ren_i,
  input  logic        id_rs2_ren_i,
  input  logic        clr_cnt_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned FL_W  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic [FL_W-1:0]   flush_left;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic              load_use;

  assign load_use = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // Zero-latency hold/flush/redirect decode, highest priority first.
  always_comb begin
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    if (!rst_n) begin
      jump_en_o = 1'b0;
    end else if (bus_hold_i) begin
      hold_pc_o    = 1'b1;
      hold_if_id_o = 1'b1;
      hold_id_ex_o = 1'b1;
    end else if (jump_en_i) begin
      jump_en_o     = 1'b1;
      jump_addr_o   = jump_addr_i;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end else if (state == FLUSH) begin
      // EX carries a bubble here, so EX hold and load-use are moot.
      flush_if_id_o = 1'b1;
    end else if (ex_hold_i) begin
      hold_pc_o    = 1'b1;
      hold_if_id_o = 1'b1;
      hold_id_ex_o = 1'b1;
    end else if (load_use) begin
      hold_pc_o     = 1'b1;
      hold_if_id_o  = 1'b1;
      flush_id_ex_o = 1'b1;
    end
  end

  // Post-redirect flush extension covering the ROM read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_left <= '0;
    end else if (bus_hold_i) begin
      state      <= state;
      flush_left <= flush_left;
    end else if (jump_en_i) begin
      if (JUMP_FLUSH_CYCLES > 1) begin
        state      <= FLUSH;
        flush_left <= FL_W'(JUMP_FLUSH_CYCLES - 1);
      end else begin
        state      <= RUN;
        flush_left <= '0;
      end
    end else if (state == FLUSH) begin
      flush_left <= flush_left - FL_W'(1);
      if (flush_left == FL_W'(1)) begin
        state <= RUN;
      end
    end
  end

  // Saturating performance counters; clear wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold_pc_o && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (jump_en_o && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (2- and 3-cycle IF/ID flush) checked each
// cycle against a rule-level reference model, with directed and random steps.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_hold_i;
  logic        bus_hold_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_ren_i;
  logic        id_rs2_ren_i;
  logic        clr_cnt_i;

  logic        je   [2];
  logic [31:0] ja   [2];
  logic        hp   [2];
  logic        hi   [2];
  logic        he   [2];
  logic        fi   [2];
  logic        fe   [2];
  logic [31:0] scnt [2];
  logic [31:0] fcnt [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.JUMP_FLUSH_CYCLES(2)) d2 (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .bus_hold_i(bus_hold_i), .ex_is_load_i(ex_is_load_i),
    .ex_rd_addr_i(ex_rd_addr_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs1_ren_i(id_rs1_ren_i),
    .id_rs2_ren_i(id_rs2_ren_i), .clr_cnt_i(clr_cnt_i),
    .jump_en_o(je[0]), .jump_addr_o(ja[0]), .hold_pc_o(hp[0]),
    .hold_if_id_o(hi[0]), .hold_id_ex_o(he[0]), .flush_if_id_o(fi[0]),
    .flush_id_ex_o(fe[0]), .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0]));

  pipe_ctrl #(.JUMP_FLUSH_CYCLES(3)) d3 (
    .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .bus_hold_i(bus_hold_i), .ex_is_load_i(ex_is_load_i),
    .ex_rd_addr_i(ex_rd_addr_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs1_ren_i(id_rs1_ren_i),
    .id_rs2_ren_i(id_rs2_ren_i), .clr_cnt_i(clr_cnt_i),
    .jump_en_o(je[1]), .jump_addr_o(ja[1]), .hold_pc_o(hp[1]),
    .hold_if_id_o(hi[1]), .hold_id_ex_o(he[1]), .flush_if_id_o(fi[1]),
    .flush_id_ex_o(fe[1]), .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1]));

  // Reference model: remaining IF/ID flush cycles and counter values per instance.
  int     jfc [2] = '{2, 3};
  int     rem [2];
  longint m_sc [2];
  longint m_fc [2];
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  typedef struct packed {
    logic        je;
    logic [31:0] ja;
    logic        hp, hi, he, fi, fe;
  } exp_t;

  function automatic exp_t expect_now(int r);
    exp_t e;
    logic lu;
    lu = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
         ((id_rs1_ren_i && id_rs1_addr_i == ex_rd_addr_i) ||
          (id_rs2_ren_i && id_rs2_addr_i == ex_rd_addr_i));
    e = '0;
    if (rst_n !== 1'b1) e = '0;
    else if (bus_hold_i) begin e.hp = 1; e.hi = 1; e.he = 1; end
    else if (jump_en_i) begin e.je = 1; e.ja = jump_addr_i; e.fi = 1; e.fe = 1; end
    else if (r > 0) e.fi = 1;
    else if (ex_hold_i) begin e.hp = 1; e.hi = 1; e.he = 1; end
    else if (lu) begin e.hp = 1; e.hi = 1; e.fe = 1; end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle, then compare both instances to the model.
  task automatic settle();
    exp_t e;
    #1;
    for (int i = 0; i < 2; i++) begin
      e = expect_now(rem[i]);
      chk($sformatf("j%0d_jump_en", jfc[i]), 32'(je[i]), 32'(e.je));
      chk($sformatf("j%0d_jump_addr", jfc[i]), ja[i], e.ja);
      chk($sformatf("j%0d_hold_pc", jfc[i]), 32'(hp[i]), 32'(e.hp));
      chk($sformatf("j%0d_hold_if_id", jfc[i]), 32'(hi[i]), 32'(e.hi));
      chk($sformatf("j%0d_hold_id_ex", jfc[i]), 32'(he[i]), 32'(e.he));
      chk($sformatf("j%0d_flush_if_id", jfc[i]), 32'(fi[i]), 32'(e.fi));
      chk($sformatf("j%0d_flush_id_ex", jfc[i]), 32'(fe[i]), 32'(e.fe));
      chk($sformatf("j%0d_stall_cnt", jfc[i]), scnt[i], 32'(m_sc[i]));
      chk($sformatf("j%0d_flush_cnt", jfc[i]), fcnt[i], 32'(m_fc[i]));
    end
  endtask

  // Apply the clock edge to the model, then move to the next drive point.
  task automatic advance();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e = expect_now(rem[i]);
      if (rst_n !== 1'b1) begin
        rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        if (!bus_hold_i) begin
          if (jump_en_i) rem[i] = jfc[i] - 1;
          else if (rem[i] > 0) rem[i] = rem[i] - 1;
        end
        if (clr_cnt_i) begin
          m_sc[i] = 0; m_fc[i] = 0;
        end else begin
          m_sc[i] = (m_sc[i] + longint'(e.hp) > SAT) ? SAT : m_sc[i] + longint'(e.hp);
          m_fc[i] = (m_fc[i] + longint'(e.je) > SAT) ? SAT : m_fc[i] + longint'(e.je);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle();
    jump_en_i = 0; ex_hold_i = 0; bus_hold_i = 0; ex_is_load_i = 0;
    ex_rd_addr_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
    id_rs1_ren_i = 0; id_rs2_ren_i = 0; clr_cnt_i = 0; jump_addr_i = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0; end
    idle();
    rst_n = 0;
    jump_en_i = 1; jump_addr_i = 32'h0000_1234;
    @(negedge clk);

    // Reset with a pending jump: everything quiet.
    step();
    settle();
    chk("rst_jump_en", 32'(je[0]), 32'd0);
    chk("rst_flush_if_id", 32'(fi[1]), 32'd0);
    advance();

    // First jump after reset.
    rst_n = 1; jump_en_i = 1; jump_addr_i = 32'h0000_0040;
    settle();
    chk("jump_addr_40", ja[0], 32'h40);
    chk("jump_flush_id_ex", 32'(fe[0]), 32'd1);
    advance();
    idle();
    settle();
    chk("flush_tail_if_id", 32'(fi[0]), 32'd1);
    chk("flush_tail_id_ex", 32'(fe[0]), 32'd0);
    advance();
    settle();
    chk("run_after_flush", 32'(fi[0]), 32'd0);
    chk("flush_cnt_one", fcnt[0], 32'd1);
    advance();

    // Jump held off by a 3-cycle bus stall.
    bus_hold_i = 1; jump_en_i = 1; jump_addr_i = 32'h0000_0080;
    repeat (3) step();
    bus_hold_i = 0;
    settle();
    chk("jump_after_bus", 32'(je[0]), 32'd1);
    chk("stall_cnt_three", scnt[0], 32'd3);
    advance();
    idle();
    repeat (3) step();

    // Load-use on rs2, then the same with x0 as destination.
    ex_is_load_i = 1; ex_rd_addr_i = 5; id_rs2_ren_i = 1; id_rs2_addr_i = 5;
    settle();
    chk("load_use_hold_pc", 32'(hp[0]), 32'd1);
    chk("load_use_bubble", 32'(fe[0]), 32'd1);
    advance();
    ex_rd_addr_i = 0; id_rs2_addr_i = 0;
    settle();
    chk("load_use_x0", 32'(hp[0]), 32'd0);
    advance();

    // EX hold for 4 cycles masks a simultaneous load-use hazard.
    ex_rd_addr_i = 7; id_rs1_ren_i = 1; id_rs1_addr_i = 7; ex_hold_i = 1;
    repeat (4) step();
    idle();
    step();

    // Jump, then a second jump in the 2nd flush cycle of the 3-cycle instance.
    clr_cnt_i = 1; step();
    clr_cnt_i = 0;
    jump_en_i = 1; jump_addr_i = 32'h100; step();
    jump_en_i = 0; step();
    jump_en_i = 1; jump_addr_i = 32'h200; step();
    idle();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("rejump_flush_%0d", k), 32'(fi[1]), (k < 2) ? 32'd1 : 32'd0);
      advance();
    end
    settle();
    chk("rejump_flush_cnt", fcnt[1], 32'd2);
    advance();

    // Saturation near the top, then clear racing a stall.
    force d2.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release d2.stall_cnt_q;
    m_sc[0] = 64'hFFFF_FFFD;
    bus_hold_i = 1;
    repeat (4) step();
    settle();
    chk("stall_saturated", scnt[0], 32'hFFFF_FFFF);
    clr_cnt_i = 1;
    advance();
    clr_cnt_i = 0;
    settle();
    chk("clear_beats_stall", scnt[0], 32'd0);
    advance();

    // Randomised traffic, including mid-flush bus stalls and resets.
    for (int n = 0; n < 400; n++) begin
      rst_n         = ($urandom_range(0, 39) != 0);
      bus_hold_i    = ($urandom_range(0, 4) == 0);
      jump_en_i     = ($urandom_range(0, 5) == 0);
      jump_addr_i   = $urandom;
      ex_hold_i     = ($urandom_range(0, 4) == 0);
      ex_is_load_i  = 1'($urandom_range(0, 1));
      ex_rd_addr_i  = 5'($urandom_range(0, 3));
      id_rs1_addr_i = 5'($urandom_range(0, 3));
      id_rs2_addr_i = 5'($urandom_range(0, 3));
      id_rs1_ren_i  = 1'($urandom_range(0, 1));
      id_rs2_ren_i  = 1'($urandom_range(0, 1));
      clr_cnt_i     = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
